// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_pkg
//  Description : Shared types and constants for the IF/MEM Wishbone arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  // Arbiter FSM encoding (ArbIdle / ArbIfBusy / ArbMemBusy)
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_IF_BUSY  = 2'b01,
    ARB_MEM_BUSY = 2'b10
  } arb_state_e;

  // Reset level and stall-bit polarity
  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;

  // Positions of the IF and MEM stages inside the ctrl stall vector
  localparam int STALL_IF_BIT  = 1;
  localparam int STALL_MEM_BIT = 4;

  // Instruction fetches are always full-word reads
  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Pipeline-side ports (IF, MEM, ctrl) and Wishbone master port
//                of the bus arbiter. master = arbiter view, slave = outside.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // ctrl
  logic [5:0]        stall_i;
  logic              flush_i;
  // instruction fetch port
  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              stallreq_if_o;
  // data memory port
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              stallreq_mem_o;
  // Wishbone classic master
  logic              bus_cyc_o;
  logic              bus_stb_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [ADDR_W-1:0] bus_adr_o;
  logic [DATA_W-1:0] bus_dat_o;
  logic [DATA_W-1:0] bus_dat_i;
  logic              bus_ack_i;

  modport master (
    input  stall_i, flush_i,
    input  if_ce_i, if_addr_i,
    output if_data_o, stallreq_if_o,
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_data_o, stallreq_mem_o,
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    input  bus_dat_i, bus_ack_i
  );

  modport slave (
    output stall_i, flush_i,
    output if_ce_i, if_addr_i,
    input  if_data_o, stallreq_if_o,
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_data_o, stallreq_mem_o,
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    output bus_dat_i, bus_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_port_hold.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_port_hold
//  Description : Per-port result holder (arb_port_hold). Keeps the data of a
//                completed access while the owning stage is stalled, and
//                generates that port's stall request and data-out mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter_port_hold
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,       // port request
  input  logic              stall_i,    // this stage's stall bit
  input  logic              flush_i,
  input  logic              ack_i,      // ack of a cycle owned by this port
  input  logic [DATA_W-1:0] bus_dat_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              stallreq_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] buf_q,  buf_d;

  // Capture the returned word on ack; remember it only if the stage cannot
  // consume it this edge. A running stage or a flush releases the result.
  always_comb begin
    done_d = done_q;
    buf_d  = buf_q;
    if (ack_i) begin
      buf_d  = bus_dat_i;
      done_d = (stall_i == STOP) & ~flush_i;
    end else if ((stall_i != STOP) || flush_i) begin
      done_d = 1'b0;
    end
  end

  // Done flag and hold buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      done_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      done_q <= done_d;
      buf_q  <= buf_d;
    end
  end

  // Live bus data in the ack cycle, held data while done, otherwise zero
  always_comb begin
    data_o = '0;
    if (ack_i) begin
      data_o = bus_dat_i;
    end else if (done_q) begin
      data_o = buf_q;
    end
  end

  // Stall drops in the ack cycle so the stage advances with data present
  assign stallreq_o = ce_i & ~done_q & ~ack_i;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one Wishbone classic bus between the IF and MEM ports
//                of the pipeline, one outstanding cycle, MEM has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   arb
);

  arb_state_e        state_q, state_d;
  logic              cyc_q,   cyc_d;
  logic              we_q,    we_d;
  logic [3:0]        sel_q,   sel_d;
  logic [ADDR_W-1:0] adr_q,   adr_d;
  logic [DATA_W-1:0] dat_q,   dat_d;

  logic if_done;
  logic mem_done;
  logic if_ack;
  logic mem_ack;
  logic unused_stall;

  // A flush discards an IF ack; a MEM ack always completes the access
  assign if_ack  = (state_q == ARB_IF_BUSY)  & arb.bus_ack_i & ~arb.flush_i;
  assign mem_ack = (state_q == ARB_MEM_BUSY) & arb.bus_ack_i;

  assign unused_stall = ^{arb.stall_i[5], arb.stall_i[3:2], arb.stall_i[0]};

  // Grant, bus-cycle sequencing and IF abort
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb.mem_ce_i && !mem_done && !arb.flush_i) begin
          state_d = ARB_MEM_BUSY;
          cyc_d   = 1'b1;
          we_d    = arb.mem_we_i;
          sel_d   = arb.mem_sel_i;
          adr_d   = arb.mem_addr_i;
          dat_d   = arb.mem_wdata_i;
        end else if (arb.if_ce_i && !if_done && !arb.flush_i) begin
          state_d = ARB_IF_BUSY;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = SEL_WORD;
          adr_d   = arb.if_addr_i;
          dat_d   = '0;
        end
      end
      ARB_IF_BUSY: begin
        if (arb.flush_i || arb.bus_ack_i) begin
          state_d = ARB_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          adr_d   = '0;
          dat_d   = '0;
        end
      end
      ARB_MEM_BUSY: begin
        // Flush is ignored here so a store is never torn mid-cycle
        if (arb.bus_ack_i) begin
          state_d = ARB_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          adr_d   = '0;
          dat_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        adr_d   = '0;
        dat_d   = '0;
      end
    endcase
  end

  // State and registered bus outputs; reset drops any cycle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= ARB_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign arb.bus_cyc_o = cyc_q;
  assign arb.bus_stb_o = cyc_q;
  assign arb.bus_we_o  = we_q;
  assign arb.bus_sel_o = sel_q;
  assign arb.bus_adr_o = adr_q;
  assign arb.bus_dat_o = dat_q;

  mem_bus_arbiter_port_hold #(.DATA_W(DATA_W)) u_if_hold (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (arb.if_ce_i),
    .stall_i    (arb.stall_i[STALL_IF_BIT]),
    .flush_i    (arb.flush_i),
    .ack_i      (if_ack),
    .bus_dat_i  (arb.bus_dat_i),
    .done_o     (if_done),
    .data_o     (arb.if_data_o),
    .stallreq_o (arb.stallreq_if_o)
  );

  mem_bus_arbiter_port_hold #(.DATA_W(DATA_W)) u_mem_hold (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (arb.mem_ce_i),
    .stall_i    (arb.stall_i[STALL_MEM_BIT]),
    .flush_i    (arb.flush_i),
    .ack_i      (mem_ack),
    .bus_dat_i  (arb.bus_dat_i),
    .done_o     (mem_done),
    .data_o     (arb.mem_data_o),
    .stallreq_o (arb.stallreq_mem_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  always #5 clk = ~clk;

  // Quiet all pipeline and slave inputs
  task automatic idle_inputs();
    arb.stall_i     = '0;
    arb.flush_i     = 1'b0;
    arb.if_ce_i     = 1'b0;
    arb.if_addr_i   = '0;
    arb.mem_ce_i    = 1'b0;
    arb.mem_we_i    = 1'b0;
    arb.mem_sel_i   = '0;
    arb.mem_addr_i  = '0;
    arb.mem_wdata_i = '0;
    arb.bus_dat_i   = '0;
    arb.bus_ack_i   = 1'b0;
  endtask

  // Inputs change just after the active edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({arb.bus_cyc_o, arb.bus_stb_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o,
         arb.if_data_o, arb.mem_data_o, arb.stallreq_if_o, arb.stallreq_mem_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%b sel=%h adr=%h if_data=%h mem_data=%h, want all zero",
               arb.bus_cyc_o, arb.bus_sel_o, arb.bus_adr_o, arb.if_data_o, arb.mem_data_o);
    end
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (arb.bus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_cyc: got %b want 0", arb.bus_cyc_o);
    end
  endtask

  task automatic test_fetch();
    next_cycle();
    arb.if_ce_i   = 1'b1;
    arb.if_addr_i = 32'h8000;
    @(negedge clk);
    checks++;
    if (arb.stallreq_if_o !== 1'b1 || arb.bus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_request: stallreq_if=%b cyc=%b want 1/0", arb.stallreq_if_o, arb.bus_cyc_o);
    end
    next_cycle();
    checks++;
    if ({arb.bus_cyc_o, arb.bus_stb_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h8000}) begin
      errors++;
      $display("FAIL fetch_bus: cyc=%b stb=%b we=%b sel=%h adr=%h want 1 1 0 f 00008000",
               arb.bus_cyc_o, arb.bus_stb_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o);
    end
    arb.bus_ack_i = 1'b1;
    arb.bus_dat_i = 32'h3C010001;
    @(negedge clk);
    checks++;
    if (arb.if_data_o !== 32'h3C010001) begin
      errors++;
      $display("FAIL fetch_data: got %h want 3c010001", arb.if_data_o);
    end
    checks++;
    if (arb.stallreq_if_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_stall: got %b want 0", arb.stallreq_if_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (arb.bus_cyc_o !== 1'b0 || arb.if_data_o !== 32'h0) begin
      errors++;
      $display("FAIL fetch_after: cyc=%b if_data=%h want 0/0", arb.bus_cyc_o, arb.if_data_o);
    end
  endtask

  task automatic test_contention();
    int          if_ack_cycle = -1;
    bit          seen = 1'b0;
    bit          mem_acked = 1'b0;
    logic [31:0] first_adr = '0;
    next_cycle();
    arb.if_ce_i    = 1'b1;
    arb.if_addr_i  = 32'h8004;
    arb.mem_ce_i   = 1'b1;
    arb.mem_we_i   = 1'b0;
    arb.mem_sel_i  = 4'hF;
    arb.mem_addr_i = 32'h100;
    for (int c = 0; c < 20 && if_ack_cycle < 0; c++) begin
      if (c > 0) next_cycle();
      arb.bus_ack_i = 1'b0;
      arb.bus_dat_i = '0;
      if (mem_acked) arb.mem_ce_i = 1'b0;
      if (arb.bus_cyc_o === 1'b1) begin
        if (!seen) begin
          seen      = 1'b1;
          first_adr = arb.bus_adr_o;
        end
        arb.bus_ack_i = 1'b1;
        arb.bus_dat_i = (arb.bus_adr_o == 32'h100) ? 32'hDEADBEEF : 32'h24020005;
      end
      @(negedge clk);
      if (arb.bus_ack_i && arb.bus_adr_o == 32'h100) begin
        mem_acked = 1'b1;
        checks++;
        if (arb.mem_data_o !== 32'hDEADBEEF || arb.stallreq_if_o !== 1'b1) begin
          errors++;
          $display("FAIL contention_mem: mem_data=%h stallreq_if=%b want deadbeef/1", arb.mem_data_o, arb.stallreq_if_o);
        end
      end else if (arb.bus_ack_i && arb.bus_adr_o == 32'h8004) begin
        if_ack_cycle = c;
        checks++;
        if (arb.if_data_o !== 32'h24020005 || arb.stallreq_if_o !== 1'b0) begin
          errors++;
          $display("FAIL contention_if: if_data=%h stallreq_if=%b want 24020005/0", arb.if_data_o, arb.stallreq_if_o);
        end
      end else begin
        checks++;
        if (arb.stallreq_if_o !== 1'b1) begin
          errors++;
          $display("FAIL contention_if_stall: cycle %0d got %b want 1", c, arb.stallreq_if_o);
        end
      end
    end
    checks++;
    if (!seen || first_adr !== 32'h100) begin
      errors++;
      $display("FAIL contention_order: first bus adr=%h seen=%b want 00000100", first_adr, seen);
    end
    // Request cycle, MEM ack, idle gap, IF ack: IF completes no earlier than the fourth cycle
    checks++;
    if (if_ack_cycle < 3) begin
      errors++;
      $display("FAIL contention_if_latency: IF ack at cycle %0d want >=3 (-1 = never)", if_ack_cycle);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_held();
    next_cycle();
    arb.stall_i    = 6'b011111;
    arb.mem_ce_i   = 1'b1;
    arb.mem_we_i   = 1'b0;
    arb.mem_sel_i  = 4'hF;
    arb.mem_addr_i = 32'h100;
    next_cycle();
    arb.bus_ack_i = 1'b1;
    arb.bus_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (arb.mem_data_o !== 32'hDEADBEEF || arb.stallreq_mem_o !== 1'b0) begin
      errors++;
      $display("FAIL held_ack: mem_data=%h stallreq_mem=%b want deadbeef/0", arb.mem_data_o, arb.stallreq_mem_o);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      arb.bus_ack_i = 1'b0;
      arb.bus_dat_i = $urandom;
      @(negedge clk);
      checks++;
      if (arb.mem_data_o !== 32'hDEADBEEF || arb.stallreq_mem_o !== 1'b0 || arb.bus_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL held_stall: cycle %0d mem_data=%h stallreq_mem=%b cyc=%b want deadbeef/0/0",
                 k, arb.mem_data_o, arb.stallreq_mem_o, arb.bus_cyc_o);
      end
    end
    next_cycle();
    arb.stall_i  = '0;
    arb.mem_ce_i = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (arb.mem_data_o !== 32'h0 || arb.bus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL held_release: mem_data=%h cyc=%b want 0/0", arb.mem_data_o, arb.bus_cyc_o);
    end
    idle_inputs();
  endtask

  task automatic test_store();
    next_cycle();
    arb.mem_ce_i    = 1'b1;
    arb.mem_we_i    = 1'b1;
    arb.mem_sel_i   = 4'b0011;
    arb.mem_addr_i  = 32'h200;
    arb.mem_wdata_i = 32'h0000ABCD;
    next_cycle();
    checks++;
    if ({arb.bus_cyc_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'h0000ABCD}) begin
      errors++;
      $display("FAIL store_bus: cyc=%b we=%b sel=%b adr=%h dat=%h want 1 1 0011 00000200 0000abcd",
               arb.bus_cyc_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o);
    end
    arb.flush_i = 1'b1;
    next_cycle();
    arb.flush_i = 1'b0;
    checks++;
    if (arb.bus_cyc_o !== 1'b1 || arb.bus_we_o !== 1'b1) begin
      errors++;
      $display("FAIL store_flush_hold: cyc=%b we=%b want 1/1", arb.bus_cyc_o, arb.bus_we_o);
    end
    arb.bus_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if (arb.stallreq_mem_o !== 1'b0) begin
      errors++;
      $display("FAIL store_ack_stall: got %b want 0", arb.stallreq_mem_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (arb.bus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL store_end_cyc: got %b want 0", arb.bus_cyc_o);
    end
  endtask

  task automatic test_flush_abort();
    next_cycle();
    arb.if_ce_i   = 1'b1;
    arb.if_addr_i = 32'h8008;
    next_cycle();
    checks++;
    if (arb.bus_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_start: cyc=%b want 1", arb.bus_cyc_o);
    end
    arb.flush_i = 1'b1;
    arb.if_ce_i = 1'b0;
    next_cycle();
    arb.flush_i = 1'b0;
    checks++;
    if (arb.bus_cyc_o !== 1'b0 || arb.bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_cyc: cyc=%b stb=%b want 0/0", arb.bus_cyc_o, arb.bus_stb_o);
    end
    arb.bus_ack_i = 1'b1;
    arb.bus_dat_i = 32'h11111111;
    @(negedge clk);
    checks++;
    if (arb.if_data_o !== 32'h0) begin
      errors++;
      $display("FAIL abort_late_ack: if_data=%h want 00000000", arb.if_data_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (arb.if_data_o !== 32'h0 || arb.bus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: if_data=%h cyc=%b want 0/0", arb.if_data_o, arb.bus_cyc_o);
    end
  endtask

  task automatic test_async_reset();
    next_cycle();
    arb.mem_ce_i   = 1'b1;
    arb.mem_sel_i  = 4'hF;
    arb.mem_addr_i = 32'h300;
    next_cycle();
    checks++;
    if (arb.bus_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: cyc=%b want 1", arb.bus_cyc_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({arb.bus_cyc_o, arb.bus_stb_o, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o,
         arb.if_data_o, arb.mem_data_o} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: cyc=%b sel=%h adr=%h mem_data=%h want all zero",
               arb.bus_cyc_o, arb.bus_sel_o, arb.bus_adr_o, arb.mem_data_o);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    arb.if_ce_i   = 1'b1;
    arb.if_addr_i = 32'h800C;
    next_cycle();
    checks++;
    if (arb.bus_cyc_o !== 1'b1 || arb.bus_adr_o !== 32'h800C) begin
      errors++;
      $display("FAIL areset_refetch_bus: cyc=%b adr=%h want 1/0000800c", arb.bus_cyc_o, arb.bus_adr_o);
    end
    arb.bus_ack_i = 1'b1;
    arb.bus_dat_i = 32'hABCD0123;
    @(negedge clk);
    checks++;
    if (arb.if_data_o !== 32'hABCD0123 || arb.stallreq_if_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_refetch_data: if_data=%h stallreq_if=%b want abcd0123/0", arb.if_data_o, arb.stallreq_if_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Random traffic: each port holds a request until its data is delivered.
  // Expected bus behaviour follows the arbitration rules at transaction level.
  task automatic test_random();
    bit          m_pend = 0, i_pend = 0;
    logic [31:0] m_adr = '0, m_dat = '0, i_adr = '0, rdata = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_sel = '0;
    bit          prev_busy = 0, prev_ack = 0, prev_m = 0, prev_i = 0;
    bit          exp_busy, owner_mem = 0, ack_now, done_m = 0, done_i = 0;
    int          waits = 0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      if (done_m) m_pend = 0;
      if (done_i) i_pend = 0;
      done_m = 0;
      done_i = 0;
      if (!m_pend && $urandom_range(0, 2) == 0) begin
        m_pend = 1;
        m_adr  = $urandom & 32'hFFFF_FFFC;
        m_we   = 1'($urandom_range(0, 1));
        m_sel  = m_we ? 4'($urandom_range(1, 15)) : 4'hF;
        m_dat  = $urandom;
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1;
        i_adr  = $urandom & 32'hFFFF_FFFC;
      end
      arb.mem_ce_i    = m_pend;
      arb.mem_we_i    = m_we;
      arb.mem_sel_i   = m_sel;
      arb.mem_addr_i  = m_adr;
      arb.mem_wdata_i = m_dat;
      arb.if_ce_i     = i_pend;
      arb.if_addr_i   = i_adr;
      // Bus rules: idle after ack, busy until ack, grant one cycle after a request on an idle bus
      if (prev_ack)       exp_busy = 0;
      else if (prev_busy) exp_busy = 1;
      else                exp_busy = prev_m | prev_i;
      checks++;
      if (arb.bus_cyc_o !== exp_busy) begin
        errors++;
        $display("FAIL rand_cyc: cycle %0d got %b want %b", c, arb.bus_cyc_o, exp_busy);
      end
      if (exp_busy && !prev_busy) begin
        owner_mem = prev_m;
        waits     = 0;
        checks++;
        if (owner_mem) begin
          if ({arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o} !== {m_we, m_sel, m_adr, m_dat}) begin
            errors++;
            $display("FAIL rand_mem_grant: cycle %0d we=%b sel=%h adr=%h dat=%h want %b %h %h %h",
                     c, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, arb.bus_dat_o, m_we, m_sel, m_adr, m_dat);
          end
        end else begin
          if ({arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o} !== {1'b0, 4'hF, i_adr}) begin
            errors++;
            $display("FAIL rand_if_grant: cycle %0d we=%b sel=%h adr=%h want 0 f %h",
                     c, arb.bus_we_o, arb.bus_sel_o, arb.bus_adr_o, i_adr);
          end
        end
      end
      ack_now       = 0;
      arb.bus_ack_i = 1'b0;
      arb.bus_dat_i = $urandom;
      if (exp_busy) begin
        if (waits >= 3 || $urandom_range(0, 1) == 1) begin
          ack_now       = 1;
          rdata         = $urandom;
          arb.bus_ack_i = 1'b1;
          arb.bus_dat_i = rdata;
        end else begin
          waits++;
        end
      end
      @(negedge clk);
      checks++;
      if (ack_now && owner_mem) begin
        done_m = 1;
        if ({arb.mem_data_o, arb.stallreq_mem_o, arb.if_data_o, arb.stallreq_if_o} !== {rdata, 1'b0, 32'h0, i_pend}) begin
          errors++;
          $display("FAIL rand_mem_ack: cycle %0d mem_data=%h sreq_mem=%b if_data=%h sreq_if=%b want %h 0 0 %b",
                   c, arb.mem_data_o, arb.stallreq_mem_o, arb.if_data_o, arb.stallreq_if_o, rdata, i_pend);
        end
      end else if (ack_now) begin
        done_i = 1;
        if ({arb.if_data_o, arb.stallreq_if_o, arb.mem_data_o, arb.stallreq_mem_o} !== {rdata, 1'b0, 32'h0, m_pend}) begin
          errors++;
          $display("FAIL rand_if_ack: cycle %0d if_data=%h sreq_if=%b mem_data=%h sreq_mem=%b want %h 0 0 %b",
                   c, arb.if_data_o, arb.stallreq_if_o, arb.mem_data_o, arb.stallreq_mem_o, rdata, m_pend);
        end
      end else begin
        if ({arb.stallreq_mem_o, arb.stallreq_if_o, arb.mem_data_o, arb.if_data_o} !== {m_pend, i_pend, 64'h0}) begin
          errors++;
          $display("FAIL rand_wait: cycle %0d sreq_mem=%b sreq_if=%b mem_data=%h if_data=%h want %b %b 0 0",
                   c, arb.stallreq_mem_o, arb.stallreq_if_o, arb.mem_data_o, arb.if_data_o, m_pend, i_pend);
        end
      end
      prev_busy = exp_busy;
      prev_ack  = ack_now;
      prev_m    = m_pend;
      prev_i    = i_pend;
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_held();
    test_store();
    test_flush_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external bus (Wishbone classic, one outstanding cycle) between the instruction-fetch port and the data-memory port of the MIPS32 pipeline. It sequences one bus cycle at a time, buffers returned read data until the requesting stage advances, and produces the IF/MEM stall requests consumed by `ctrl`. It also honours `ctrl`'s `flush` and `stall` outputs.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high (`RstEnable`)
- stall_i  in  6  `stall` from `ctrl`; bit1 = IF stage, bit4 = MEM stage
- flush_i  in  1  `flush` from `ctrl`
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction
- stallreq_if_o  out  1  drives `stallreq_from_if`
- mem_ce_i  in  1  data access request
- mem_we_i  in  1  1 = store
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_data_o  out  32  load data
- stallreq_mem_o  out  1  drives `stallreq_from_mem`
- bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  bus strobes
- bus_sel_o  out  4  bus byte enables
- bus_adr_o  out  32  bus address
- bus_dat_o  out  32  bus write data
- bus_dat_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY. Each port has a done flag and a 32-bit hold buffer.
- IDLE: if mem_ce_i and not mem_done and not flush_i, go to MEM_BUSY. Else if if_ce_i and not if_done and not flush_i, go to IF_BUSY. MEM has fixed priority.
- On entry to IF_BUSY: register cyc=stb=1, we=0, sel=4'b1111, adr=if_addr_i.
- On entry to MEM_BUSY: register cyc=stb=1, and we/sel/adr/dat from the MEM port.
- BUSY with bus_ack_i=1:
  - drop cyc/stb/we/sel/adr/dat to 0 on the next edge; return to IDLE;
  - copy bus_dat_i to the port's hold buffer;
  - set the port's done flag if its stall bit (stall_i[1] for IF, stall_i[4] for MEM) is 1.
- Done flag clears when the port's stall bit is 0 or flush_i=1.
- Data outputs:
  - during the ack cycle, the owning port outputs bus_dat_i;
  - while done, it outputs its hold buffer;
  - otherwise it outputs 0.
- stallreq_x_o = x_ce_i & ~x_done & ~(state owns x & bus_ack_i). This is combinational, and it is also asserted while the other port owns the bus.
- Flush:
  - flush_i in IF_BUSY aborts the fetch. cyc/stb drop on the next edge, state returns to IDLE, and any ack in that cycle is discarded.
  - flush_i in MEM_BUSY does not abort; the store or load runs to ack so a bus write is never torn.
  - flush_i in IDLE blocks new grants that cycle.
- Reset: state=IDLE, all bus outputs 0, done flags 0, buffers 0, both data outputs 0. A bus cycle in progress is dropped immediately (asynchronous).

## Timing
- Grant is decided in the cycle the request is seen; cyc/stb assert on the following edge.
- Minimum access is 2 cycles: request cycle plus ack cycle with a zero-wait slave.
- The stall request falls in the same cycle as the ack, so the pipeline advances on that edge with the data present.
- After ack the bus is idle for at least one cycle. A back-to-back MEM→IF grant therefore has a 1-cycle gap.
- IF and MEM requesting together: MEM completes first. IF is granted on the first IDLE cycle after, and stallreq_if_o stays 1 throughout.
- A slave that never acks stalls the pipeline indefinitely; no timeout.

## Structure
- FSM state encodings (2-bit) belong in `defines.v` as `ArbIdle`, `ArbIfBusy` and `ArbMemBusy`. Reuse `Stop`, `ZeroWord` and `RstEnable`.
- One sub-module, `arb_port_hold`, instantiated twice. It contains the done flag, the hold buffer, the stallreq equation and the data-out mux.

## Test plan
- Zero-wait fetch: if_ce_i=1, if_addr_i=32'h8000, slave acks with 32'h3C010001 on the second cycle. Required: cyc high for exactly 1 cycle, if_data_o=32'h3C010001 in the ack cycle, stallreq_if_o low in the ack cycle.
- Contention: if_ce_i and mem_ce_i (load from 32'h100, slave returns 32'hDEADBEEF) both rise together. Required: MEM served first. stallreq_if_o stays high until the IF ack, which occurs ≥4 cycles after the start.
- Held result: MEM load acks while stall_i=6'b011111 for 3 more cycles. Required: mem_data_o holds 32'hDEADBEEF, stallreq_mem_o=0 and no new bus cycle for those cycles. The buffer is released when stall_i=0.
- Store: mem_we_i=1, sel=4'b0011, adr=32'h200, dat=32'h0000ABCD. Required: bus_we_o=1 and bus_sel_o=4'b0011. flush_i raised mid-cycle does not drop cyc before ack.
- Flush abort: flush_i pulses during IF_BUSY. Required: cyc=0 on the next edge, state IDLE, and a late ack produces no if_data_o change.
- Async reset: assert rst during MEM_BUSY between edges. Required: bus_cyc_o=0 immediately and all outputs 0. After release, the first request completes normally.
